// File: rtl/y86_pkg.sv
// Shared Y86 status encodings, fail codes and run-monitor state encoding.
package y86_pkg;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [1:0] FAIL_NONE = 2'd0;
  localparam logic [1:0] FAIL_ADR  = 2'd1;
  localparam logic [1:0] FAIL_INS  = 2'd2;
  localparam logic [1:0] FAIL_TMO  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_e;

endpackage

// File: rtl/y86_stat_decode.sv
// Classifies one 3-bit Y86 status channel; codes 0 and 5..7 are illegal.
module y86_stat_decode
  import y86_pkg::*;
(
  input  logic [2:0] status,
  output logic       is_hlt,
  output logic       is_adr,
  output logic       is_ins,
  output logic       is_bad
);

  assign is_hlt = (status == STAT_HLT);
  assign is_adr = (status == STAT_ADR);
  assign is_ins = (status == STAT_INS);
  assign is_bad = (status == 3'd0) || (status > STAT_INS);

endmodule

// File: rtl/y86_run_monitor.sv
// Watches NCH Y86 status channels and latches the outcome of a run:
// all halted, first fault, or watchdog timeout.
//
// state | meaning
// IDLE  | out of reset, no result held
// RUN   | counting cycles, sampling status_in
// DRAIN | result final, waiting DRAIN_CYC clocks before done
// DONE  | result held until next start
module y86_run_monitor
  import y86_pkg::*;
#(
  parameter int NCH       = 1,
  parameter int CNT_W     = 32,
  parameter int MAX_CYC   = 100000,
  parameter int DRAIN_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3*NCH-1:0]   status_in,
  output logic               running,
  output logic               done,
  output logic               pass,
  output logic [1:0]         fail_code,
  output logic [2:0]         fail_ch,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [NCH-1:0]     halted_mask
);

  mon_state_e state;
  logic [3:0] drain_cnt;

  logic [NCH-1:0] hlt_vec, adr_vec, ins_vec, bad_vec;

  for (genvar g = 0; g < NCH; g++) begin : g_dec
    y86_stat_decode u_dec (
      .status (status_in[3*g +: 3]),
      .is_hlt (hlt_vec[g]),
      .is_adr (adr_vec[g]),
      .is_ins (ins_vec[g]),
      .is_bad (bad_vec[g])
    );
  end

  logic             flt_any;
  logic [1:0]       flt_code;
  logic [2:0]       flt_ch;
  logic [CNT_W-1:0] cnt_next;
  logic [NCH-1:0]   mask_next;
  logic             all_hlt;
  logic             timeout;

  // Scan high to low so the lowest faulting index is the one that sticks.
  always_comb begin
    flt_any  = 1'b0;
    flt_code = FAIL_NONE;
    flt_ch   = 3'd0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (adr_vec[k] || ins_vec[k] || bad_vec[k]) begin
        flt_any  = 1'b1;
        flt_ch   = 3'(k);
        flt_code = adr_vec[k] ? FAIL_ADR : (ins_vec[k] ? FAIL_INS : FAIL_TMO);
      end
    end
  end

  assign cnt_next  = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);
  assign mask_next = halted_mask | hlt_vec;
  assign all_hlt   = &mask_next;
  assign timeout   = (MAX_CYC != 0) && (cnt_next == CNT_W'(MAX_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      drain_cnt   <= 4'd0;
      running     <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_code   <= FAIL_NONE;
      fail_ch     <= 3'd0;
      cycle_count <= '0;
      halted_mask <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state       <= ST_RUN;
            running     <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= FAIL_NONE;
            fail_ch     <= 3'd0;
            cycle_count <= '0;
            halted_mask <= '0;
          end
        end
        ST_RUN: begin
          cycle_count <= cnt_next;
          halted_mask <= mask_next;
          if (flt_any || all_hlt || timeout) begin
            state     <= ST_DRAIN;
            drain_cnt <= 4'(DRAIN_CYC - 1);
          end
          if (flt_any) begin
            fail_code <= flt_code;
            fail_ch   <= flt_ch;
          end else if (all_hlt) begin
            pass <= 1'b1;
          end else if (timeout) begin
            fail_code <= FAIL_TMO;
            fail_ch   <= 3'd0;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 4'd0) begin
            state   <= ST_DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
